// File: rtl/cordic_job_scheduler.sv
// ---------------------------------------------------------------------------
// cordic_job_scheduler
//
// Shares one iterative CORDIC core between NREQ job sources. Each requester
// offers a job (mode, in, in2) on a valid/ready port; a round-robin arbiter
// picks one job at a time. The job is loaded into the core, the core's
// iterations are counted, x/y/z are captured when the core is done, and the
// result is returned with the requester index on a valid/ready result port.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. The scheduler raises at most one req_ready bit, and only in
// IDLE. Requesters hold req_* stable while valid and not ready; a requester
// may drop req_valid before it is granted. res_valid stays high, with res_*
// stable, until the consumer raises res_ready.
//
// Ports
//   clk, rst             clock (rising edge) and asynchronous active-high reset
//   req_valid/req_ready  per-requester job handshake (req_ready is one-hot)
//   req_mode             3 bits per requester, slice k = [3k+2:3k]
//   req_in, req_in2      W bits per requester, slice k = [Wk+W-1:Wk]
//   core_start           one-cycle pulse, core restarts its iteration count
//   core_mode/in/in2     job operands to the core, stable for the whole job
//   core_x/y/z           core results
//   res_valid/res_ready  result handshake
//   res_id               index of the requester that owns the result
//   res_x/y/z            captured core results (zero for illegal modes)
//   res_err              job had an illegal mode (6 or 7)
//   busy                 scheduler is not idle
//
// Modes 0-3 take LAT core cycles, hyperbolic modes 4 and 5 take
// LAT+HYP_EXTRA. Modes 6 and 7 never reach the core and complete at once
// with res_err set.
// ---------------------------------------------------------------------------
module cordic_job_scheduler #(
   parameter int NREQ      = 4,
   parameter int W         = 32,
   parameter int LAT       = 10,
   parameter int HYP_EXTRA = 1,
   localparam int ID_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [3*NREQ-1:0]   req_mode,
   input  logic [W*NREQ-1:0]   req_in,
   input  logic [W*NREQ-1:0]   req_in2,
   output logic                core_start,
   output logic [2:0]          core_mode,
   output logic [W-1:0]        core_in,
   output logic [W-1:0]        core_in2,
   input  logic [W-1:0]        core_x,
   input  logic [W-1:0]        core_y,
   input  logic [W-1:0]        core_z,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [ID_W-1:0]     res_id,
   output logic [W-1:0]        res_x,
   output logic [W-1:0]        res_y,
   output logic [W-1:0]        res_z,
   output logic                res_err,
   output logic                busy
);

   // One extra bit so rr_ptr + offset can be reduced modulo NREQ without
   // overflowing, also for NREQ values that are not a power of two.
   localparam int               ID1_W  = ID_W + 1;
   localparam logic [ID1_W-1:0] NREQ_W = ID1_W'(NREQ);

   // The RUN counter is loaded with L-1 and counts down to 0, so RUN lasts
   // exactly L cycles.
   localparam int               L_MAX    = LAT + HYP_EXTRA;
   localparam int               CNT_W    = (L_MAX > 1) ? $clog2(L_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_CIRC = CNT_W'(LAT - 1);
   localparam logic [CNT_W-1:0] CNT_HYP  = CNT_W'(L_MAX - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            state;
   state_t            state_next;

   logic [ID_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]  cnt;

   logic              any_valid;
   logic [ID_W-1:0]   grant_idx;
   logic [ID1_W-1:0]  ptr_inc;
   logic [ID_W-1:0]   ptr_next;
   logic              accept;

   logic [2:0]        sel_mode;
   logic [W-1:0]      sel_in;
   logic [W-1:0]      sel_in2;

   logic [2:0]        mode_arr [NREQ];
   logic [W-1:0]      in_arr   [NREQ];
   logic [W-1:0]      in2_arr  [NREQ];

   // Modes 6 and 7 have no core operation.
   function automatic logic mode_illegal(input logic [2:0] m);
      return m[2] & m[1];
   endfunction

   // Modes 4 and 5 are hyperbolic and need the core's extra setup cycle.
   function automatic logic mode_hyp(input logic [2:0] m);
      return m[2] & ~m[1];
   endfunction

   // -----------------------------------------------------------------------
   // Per-requester views of the flat request buses
   // -----------------------------------------------------------------------
   for (genvar k = 0; k < NREQ; k++) begin : g_unpack
      assign mode_arr[k] = req_mode[3*k +: 3];
      assign in_arr[k]   = req_in[W*k +: W];
      assign in2_arr[k]  = req_in2[W*k +: W];
   end

   // -----------------------------------------------------------------------
   // Round-robin arbiter: first valid requester at or above rr_ptr, wrapping
   // modulo NREQ. The loop runs from the farthest offset down to offset 0, so
   // the last hit written (the nearest one) wins.
   // -----------------------------------------------------------------------
   always_comb begin
      logic [ID1_W-1:0] cand;
      any_valid = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = {1'b0, rr_ptr} + ID1_W'(i);
         if (cand >= NREQ_W) begin
            cand = cand - NREQ_W;
         end
         if (req_valid[cand[ID_W-1:0]]) begin
            any_valid = 1'b1;
            grant_idx = cand[ID_W-1:0];
         end
      end
   end

   assign sel_mode = mode_arr[grant_idx];
   assign sel_in   = in_arr[grant_idx];
   assign sel_in2  = in2_arr[grant_idx];

   // Pointer moves to the requester after the one just granted.
   assign ptr_inc  = {1'b0, grant_idx} + ID1_W'(1);
   assign ptr_next = (ptr_inc >= NREQ_W) ? '0 : ptr_inc[ID_W-1:0];

   assign accept   = (state == IDLE) && any_valid;

   // -----------------------------------------------------------------------
   // FSM: state register
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // -----------------------------------------------------------------------
   // FSM: next state
   // -----------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (any_valid) begin
               state_next = mode_illegal(sel_mode) ? DONE : LOAD;
            end
         end
         LOAD: begin
            state_next = RUN;
         end
         RUN: begin
            if (cnt == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // FSM: outputs (all decoded from registered state, plus req_valid for the
   // grant strobe)
   // -----------------------------------------------------------------------
   always_comb begin
      core_start = 1'b0;
      res_valid  = 1'b0;
      busy       = 1'b1;
      req_ready  = '0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (any_valid) begin
               req_ready[grant_idx] = 1'b1;
            end
         end
         LOAD: begin
            core_start = 1'b1;
         end
         DONE: begin
            res_valid = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // Datapath: job latch, iteration counter, result capture
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         cnt       <= '0;
         core_mode <= '0;
         core_in   <= '0;
         core_in2  <= '0;
         res_id    <= '0;
         res_err   <= 1'b0;
         res_x     <= '0;
         res_y     <= '0;
         res_z     <= '0;
      end else begin
         // The core operands are only ever written here, so they stay put
         // for the whole job and keep the last job's values afterwards.
         if (accept) begin
            rr_ptr    <= ptr_next;
            core_mode <= sel_mode;
            core_in   <= sel_in;
            core_in2  <= sel_in2;
            res_id    <= grant_idx;
            res_err   <= mode_illegal(sel_mode);
            if (mode_illegal(sel_mode)) begin
               res_x <= '0;
               res_y <= '0;
               res_z <= '0;
            end
         end

         case (state)
            LOAD: begin
               cnt <= mode_hyp(core_mode) ? CNT_HYP : CNT_CIRC;
            end
            RUN: begin
               // cnt==0 marks the last RUN cycle; the core's outputs are
               // valid during it and are taken unmodified.
               if (cnt == '0) begin
                  res_x <= core_x;
                  res_y <= core_y;
                  res_z <= core_z;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_job_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cordic_job_scheduler
//
// Directed bench for cordic_job_scheduler with NREQ=4, W=32, LAT=10,
// HYP_EXTRA=1. A behavioural core stub answers each job: its x/y/z are only
// meaningful during the single cycle that is L-1 cycles after the cycle
// following core_start, and carry a poison pattern otherwise. Mode 0 returns
// cos/sin of the operand taken as Q16.16 degrees; other legal modes return a
// simple fixed function of the operands.
// ---------------------------------------------------------------------------
module tb_cordic_job_scheduler;

   localparam int NREQ      = 4;
   localparam int W         = 32;
   localparam int LAT       = 10;
   localparam int HYP_EXTRA = 1;
   localparam int ID_W      = 2;
   localparam int SB_W      = ID_W + 1 + 3 * W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [3*NREQ-1:0] req_mode;
   logic [W*NREQ-1:0] req_in;
   logic [W*NREQ-1:0] req_in2;
   logic              core_start;
   logic [2:0]        core_mode;
   logic [W-1:0]      core_in;
   logic [W-1:0]      core_in2;
   logic [W-1:0]      core_x;
   logic [W-1:0]      core_y;
   logic [W-1:0]      core_z;
   logic              res_valid;
   logic              res_ready;
   logic [ID_W-1:0]   res_id;
   logic [W-1:0]      res_x;
   logic [W-1:0]      res_y;
   logic [W-1:0]      res_z;
   logic              res_err;
   logic              busy;

   cordic_job_scheduler #(
      .NREQ      (NREQ),
      .W         (W),
      .LAT       (LAT),
      .HYP_EXTRA (HYP_EXTRA)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_mode   (req_mode),
      .req_in     (req_in),
      .req_in2    (req_in2),
      .core_start (core_start),
      .core_mode  (core_mode),
      .core_in    (core_in),
      .core_in2   (core_in2),
      .core_x     (core_x),
      .core_y     (core_y),
      .core_z     (core_z),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_id     (res_id),
      .res_x      (res_x),
      .res_y      (res_y),
      .res_z      (res_z),
      .res_err    (res_err),
      .busy       (busy)
   );

   // ---------------- core model ----------------
   function automatic logic [3*W-1:0] core_model(input logic [2:0] m,
                                                 input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
      real          rad;
      int           xi;
      int           yi;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] z;
      if (m == 3'd0) begin
         rad = ($itor($signed(a)) / 65536.0) * 3.14159265358979 / 180.0;
         xi  = int'($cos(rad) * 65536.0);
         yi  = int'($sin(rad) * 65536.0);
         x   = xi;
         y   = yi;
         z   = '0;
      end else begin
         x = a ^ 32'h5A5A_0000 ^ {29'd0, m};
         y = b + {29'd0, m};
         z = a - b;
      end
      return {x, y, z};
   endfunction

   logic stub_active;
   int   stub_age;
   int   stub_lat;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         stub_active <= 1'b0;
         stub_age    <= 0;
      end else if (core_start) begin
         stub_active <= 1'b1;
         stub_age    <= 0;
      end else if (stub_active) begin
         stub_age <= stub_age + 1;
      end
   end

   always_comb begin
      stub_lat = (core_mode == 3'd4 || core_mode == 3'd5) ? LAT + HYP_EXTRA : LAT;
      {core_x, core_y, core_z} = {3{32'hBAD0_0BAD}};
      if (stub_active && stub_age == stub_lat - 1) begin
         {core_x, core_y, core_z} = core_model(core_mode, core_in, core_in2);
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [SB_W-1:0] exp_result(input int k, input logic [2:0] m,
                                                  input logic [W-1:0] a, input logic [W-1:0] b);
      logic [ID_W-1:0] id;
      id = ID_W'(k);
      if (m[2] & m[1]) return {id, 1'b1, {(3*W){1'b0}}};
      return {id, 1'b0, core_model(m, a, b)};
   endfunction

   // ---------------- scoreboard / monitor ----------------
   logic [2:0]      drv_mode [NREQ];
   logic [W-1:0]    drv_in   [NREQ];
   logic [W-1:0]    drv_in2  [NREQ];

   logic [SB_W-1:0] exp_q[$];
   int              grant_q[$];
   int              grant_cyc_q[$];
   int              multi_grant    = 0;
   int              busy_ready     = 0;
   int              start_cnt      = 0;
   int              last_start_cyc = -1;

   always begin
      @(negedge clk);
      #2;
      if (!rst) begin
         if ($countones(req_ready) > 1) multi_grant++;
         if (busy && req_ready != '0) busy_ready++;
         if (core_start) begin
            start_cnt++;
            last_start_cyc = cyc;
         end
         for (int k = 0; k < NREQ; k++) begin
            if (req_ready[k]) begin
               grant_q.push_back(k);
               grant_cyc_q.push_back(cyc);
               exp_q.push_back(exp_result(k, drv_mode[k], drv_in[k], drv_in2[k]));
            end
         end
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) check("res_unexpected", 1, 0);
            else check("res_sb", {res_id, res_err, res_x, res_y, res_z}, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_req(input int k, input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
      drv_mode[k]        = m;
      drv_in[k]          = a;
      drv_in2[k]         = b;
      req_mode[3*k +: 3] = m;
      req_in[W*k +: W]   = a;
      req_in2[W*k +: W]  = b;
   endtask

   // Called at a falling edge; returns at the falling edge of the LOAD cycle
   // with req_valid[k] dropped again. t is the cycle req_ready[k] was seen.
   task automatic issue(input int k, output int t);
      req_valid[k] = 1'b1;
      t = -1;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (req_ready[k]) begin
            t = cyc;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      req_valid[k] = 1'b0;
      check("grant_seen", t >= 0, 1);
   endtask

   // Waits for res_valid; counts cycles on the way where core_mode differs
   // from m.
   task automatic wait_res(input logic [2:0] m, output int tv, output int bad_mode);
      tv = -1;
      bad_mode = 0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (core_mode !== m) bad_mode++;
         if (res_valid) begin
            tv = cyc;
            break;
         end
         @(negedge clk);
      end
      check("res_seen", tv >= 0, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0 && !busy) break;
         @(negedge clk);
      end
      check("drain", {exp_q.size() == 0, busy}, {1'b1, 1'b0});
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   int              t;
   int              tv;
   int              bad;
   int              s0;
   int              n0;
   int              h;
   int              cnt_a;
   int              cnt_b;
   int              cnt_c;
   int              dx;
   int              dy;
   int              t3_ids[5] = '{0, 1, 2, 3, 0};
   logic [SB_W-1:0] snap;

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_mode  = '0;
      req_in    = '0;
      req_in2   = '0;
      res_ready = 1'b1;
      for (int k = 0; k < NREQ; k++) set_req(k, 3'd0, '0, '0);

      // Reset state
      #1;
      check("rst_busy", busy, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_core_start", core_start, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_core_ops", {core_mode, core_in, core_in2}, 0);
      check("rst_res", {res_id, res_err, res_x, res_y, res_z}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 1. Reset in the middle of RUN, with cnt at 4
      set_req(0, 3'd1, 32'h0001_0000, 32'h0002_0000);
      issue(0, t);
      repeat (6) @(negedge clk);
      #3;
      check("t1_busy_before", busy, 1);
      rst = 1'b1;
      #1;
      check("t1_async_drop", {busy, res_valid, core_start}, 3'b000);
      check("t1_core_ops_clr", {core_mode, core_in, core_in2}, 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      cnt_a = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (res_valid || busy) cnt_a++;
      end
      check("t1_no_result", cnt_a, 0);

      // 3. All requesters valid, res_ready high: round robin from pointer 0
      grant_q.delete();
      grant_cyc_q.delete();
      for (int k = 0; k < NREQ; k++) set_req(k, 3'(k), 32'h0001_0000 * (k + 1), 32'h0000_0100 * (k + 3));
      req_valid = 4'b1111;
      for (int i = 0; i < 200; i++) begin
         #3;
         if (grant_q.size() >= 5) break;
         @(negedge clk);
      end
      @(negedge clk);
      req_valid = '0;
      check("t3_grant_count", grant_q.size(), 5);
      for (int i = 0; i < 5; i++) check("t3_grant_id", grant_q[i], t3_ids[i]);
      for (int i = 1; i < 5; i++) check("t3_grant_gap", grant_cyc_q[i] - grant_cyc_q[i-1], 13);
      drain();

      // 2. Single mode-0 job from requester 2, 45 degrees
      set_req(2, 3'd0, 32'h002D_0000, 32'h0000_0000);
      issue(2, t);
      #3;
      check("t2_start_cyc", last_start_cyc, t + 1);
      wait_res(3'd0, tv, bad);
      check("t2_latency", tv - t, 12);
      check("t2_res_id", res_id, 2);
      check("t2_err", res_err, 0);
      dx = int'($signed(res_x)) - 32'h0000B505;
      dy = int'($signed(res_y)) - 32'h0000B505;
      check("t2_x_near", (dx <= 64) && (dx >= -64), 1);
      check("t2_y_near", (dy <= 64) && (dy >= -64), 1);
      check("t2_mode_stable", bad, 0);
      @(negedge clk);
      drain();

      // 4. Hyperbolic mode 5 job from requester 1
      set_req(1, 3'd5, 32'h0000_8000, 32'h0000_4000);
      issue(1, t);
      #3;
      check("t4_start_cyc", last_start_cyc, t + 1);
      wait_res(3'd5, tv, bad);
      check("t4_latency", tv - t, 13);
      check("t4_mode_stable", bad, 0);
      check("t4_res", {res_id, res_err, res_x, res_y, res_z},
            exp_result(1, 3'd5, 32'h0000_8000, 32'h0000_4000));
      @(negedge clk);
      drain();

      // 5. Illegal mode 7 from requester 3
      set_req(3, 3'd7, 32'h1234_5678, 32'h9ABC_DEF0);
      s0 = start_cnt;
      issue(3, t);
      wait_res(3'd7, tv, bad);
      check("t5_latency", tv - t, 1);
      check("t5_err", res_err, 1);
      check("t5_res_zero", {res_x, res_y, res_z}, 0);
      check("t5_res_id", res_id, 3);
      repeat (3) @(negedge clk);
      check("t5_no_start", start_cnt - s0, 0);
      drain();

      // 6. Result held back for 20 cycles while every requester waits
      res_ready = 1'b0;
      for (int k = 0; k < NREQ; k++) set_req(k, 3'd2, 32'h0003_0000 + k, 32'h0000_0700 - k);
      n0 = grant_q.size();
      req_valid = 4'b1111;
      wait_res(3'd2, tv, bad);
      check("t6_first_grant", grant_q[n0], 0);
      snap  = {res_id, res_err, res_x, res_y, res_z};
      cnt_a = 0;
      cnt_b = 0;
      cnt_c = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if ({res_id, res_err, res_x, res_y, res_z} !== snap) cnt_a++;
         if (req_ready != '0) cnt_b++;
         if (!res_valid) cnt_c++;
      end
      check("t6_res_stable", cnt_a, 0);
      check("t6_ready_low", cnt_b, 0);
      check("t6_valid_held", cnt_c, 0);
      check("t6_value", snap, exp_result(0, 3'd2, 32'h0003_0000, 32'h0000_0700));
      @(negedge clk);
      res_ready = 1'b1;
      h = cyc;
      for (int i = 0; i < 20; i++) begin
         #3;
         if (grant_q.size() > n0 + 1) break;
         @(negedge clk);
      end
      @(negedge clk);
      req_valid = '0;
      check("t6_next_grant_id", grant_q[n0 + 1], 1);
      check("t6_next_grant_cyc", grant_cyc_q[n0 + 1] - h, 1);
      drain();

      // Whole-run invariants
      check("one_hot_ready", multi_grant, 0);
      check("ready_only_idle", busy_ready, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
